// File: rtl/crc_ram_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : crc_ram_scan_ctrl
// Description : Reads a byte block from the 256x8 CRC RAM, folds it into a
//               CRC-16/CCITT-FALSE and optionally writes the CRC back.
// Revision    : 1.0 - initial release
// ============================================================================
module crc_ram_scan_ctrl #(
    parameter logic [15:0] POLY     = 16'h1021,
    parameter logic [15:0] CRC_INIT = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  start_addr,
    input  logic [8:0]  length,
    input  logic        write_back,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] crc_out,
    output logic [7:0]  mem_address,
    output logic        mem_chipselect,
    output logic        mem_write,
    output logic [7:0]  mem_writedata,
    input  logic [7:0]  mem_readdata
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_RD    = 3'd1;
    localparam logic [2:0] c_FOLD  = 3'd2;
    localparam logic [2:0] c_WB_HI = 3'd3;
    localparam logic [2:0] c_WB_LO = 3'd4;
    localparam logic [2:0] c_FIN   = 3'd5;

    logic [2:0]  r_state;
    logic [7:0]  r_base;
    logic [8:0]  r_len;
    logic [8:0]  r_cnt;
    logic        r_wb;
    logic        r_err;
    logic [15:0] r_crc;
    logic [15:0] r_crc_out;
    logic [15:0] w_fold;
    logic        w_len_bad;
    logic [7:0]  w_wb_addr;

    // Eight MSB-first shift/XOR steps unrolled into a single cycle.
    function automatic logic [15:0] f_fold(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ POLY;
            else                 c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    assign w_fold    = f_fold(r_crc, mem_readdata);
    assign w_len_bad = (length == 9'd0) || (length > 9'd256);
    assign w_wb_addr = r_base + r_len[7:0];
    assign crc_out   = r_crc_out;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= c_IDLE;
            r_base    <= 8'd0;
            r_len     <= 9'd0;
            r_cnt     <= 9'd0;
            r_wb      <= 1'b0;
            r_err     <= 1'b0;
            r_crc     <= 16'd0;
            r_crc_out <= 16'd0;
        end else if (r_state == c_IDLE) begin
            if (start) begin
                r_base  <= start_addr;
                r_len   <= length;
                r_wb    <= write_back;
                r_crc   <= CRC_INIT;
                r_cnt   <= 9'd0;
                r_err   <= w_len_bad;
                r_state <= w_len_bad ? c_FIN : c_RD;
            end
        end else if (abort) begin
            r_state <= c_IDLE;
        end else begin
            case (r_state)
                c_RD: begin
                    // The byte addressed in the previous cycle arrives now.
                    if (r_cnt != 9'd0) r_crc <= w_fold;
                    r_cnt <= r_cnt + 9'd1;
                    if (r_cnt == r_len - 9'd1) r_state <= c_FOLD;
                end
                c_FOLD: begin
                    r_crc <= w_fold;
                    if (r_wb) begin
                        r_state <= c_WB_HI;
                    end else begin
                        r_crc_out <= w_fold;
                        r_state   <= c_FIN;
                    end
                end
                c_WB_HI: r_state <= c_WB_LO;
                c_WB_LO: begin
                    r_crc_out <= r_crc;
                    r_state   <= c_FIN;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    always_comb begin
        busy           = (r_state != c_IDLE);
        done           = (r_state == c_FIN);
        error          = (r_state == c_FIN) && r_err;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        mem_address    = 8'd0;
        mem_writedata  = 8'd0;
        case (r_state)
            c_RD: begin
                mem_chipselect = 1'b1;
                mem_address    = r_base + r_cnt[7:0];
            end
            c_WB_HI: begin
                mem_chipselect = 1'b1;
                mem_write      = 1'b1;
                mem_address    = w_wb_addr;
                mem_writedata  = r_crc[15:8];
            end
            c_WB_LO: begin
                mem_chipselect = 1'b1;
                mem_write      = 1'b1;
                mem_address    = w_wb_addr + 8'd1;
                mem_writedata  = r_crc[7:0];
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire
